nv_ram_fifo_ctrl_256x64: RTL and testbench

NV_RAM_FIFO_CTRL_256X64 -- requirements
Module: nv_ram_fifo_ctrl_256x64

---
 rtl/nv_ram_fifo_ctrl_256x64.sv | 129 ++++++++++++
 tb/tb_nv_ram_fifo_ctrl_256x64.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nv_ram_fifo_ctrl_256x64.sv
// Valid/ready FIFO controller wrapping an external 256x64 two-port RAM with a 2-entry output buffer.
// Push-to-rd_pvld latency 3 cycles; wr_prdy depends only on registered RAM occupancy, never on rd_prdy.
module nv_ram_fifo_ctrl_256x64 #(
  parameter int ASSERT_ON = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_pvld,
  output logic        wr_prdy,
  input  logic [63:0] wr_pd,
  output logic        rd_pvld,
  input  logic        rd_prdy,
  output logic [63:0] rd_pd,
  output logic        ram_we,
  output logic [7:0]  ram_wa,
  output logic [63:0] ram_di,
  output logic        ram_re,
  output logic [7:0]  ram_ra,
  input  logic [63:0] ram_dout,
  input  logic [31:0] pwrbus_ram_pd_in,
  output logic [31:0] pwrbus_ram_pd,
  output logic [9:0]  fifo_count,
  output logic        idle
);

  logic [7:0]  wr_ptr_q, wr_ptr_d;
  logic [7:0]  rd_ptr_q, rd_ptr_d;
  logic [8:0]  ram_cnt_q, ram_cnt_d;
  logic        inflight_q;
  logic [1:0]  ob_cnt_q, ob_cnt_d;
  logic [63:0] ob0_q, ob0_d;
  logic [63:0] ob1_q, ob1_d;
  logic [9:0]  fifo_count_q, fifo_count_d;

  logic        push;
  logic        pop;
  logic        rd_issue;
  logic [1:0]  ob_after_pop;

  assign pwrbus_ram_pd = pwrbus_ram_pd_in;

  // Visible outputs are forced to their reset values while rst is high so they are
  // clean from the first reset cycle, not only after the first reset edge.
  assign wr_prdy    = ~rst & ~ram_cnt_q[8];
  assign rd_pvld    = ~rst & (ob_cnt_q != 2'd0);
  assign rd_pd      = rst ? 64'd0 : ob0_q;
  assign fifo_count = rst ? 10'd0 : fifo_count_q;
  assign idle       = rst | (fifo_count_q == 10'd0);

  assign push = wr_pvld & wr_prdy;
  assign pop  = rd_pvld & rd_prdy;

  // A read may issue only if its data will find a free buffer slot once the
  // current pop and the word already in flight are accounted for.
  assign ob_after_pop = ob_cnt_q - {1'b0, pop};
  assign rd_issue     = ~rst & (ram_cnt_q != 9'd0)
                      & (({1'b0, ob_after_pop} + {2'b00, inflight_q}) < 3'd2);

  assign ram_we = push;
  assign ram_wa = wr_ptr_q;
  assign ram_di = wr_pd;
  assign ram_re = rd_issue;
  assign ram_ra = rd_ptr_q;

  always_comb begin
    wr_ptr_d = push     ? wr_ptr_q + 8'd1 : wr_ptr_q;
    rd_ptr_d = rd_issue ? rd_ptr_q + 8'd1 : rd_ptr_q;

    ram_cnt_d = ram_cnt_q;
    case ({push, rd_issue})
      2'b10:   ram_cnt_d = ram_cnt_q + 9'd1;
      2'b01:   ram_cnt_d = ram_cnt_q - 9'd1;
      default: ram_cnt_d = ram_cnt_q;
    endcase

    ob_cnt_d = ob_cnt_q;
    case ({inflight_q, pop})
      2'b10:   ob_cnt_d = ob_cnt_q + 2'd1;
      2'b01:   ob_cnt_d = ob_cnt_q - 2'd1;
      default: ob_cnt_d = ob_cnt_q;
    endcase

    // Head is always ob0; a pop shifts, and the captured word lands behind whatever remains.
    ob0_d = ob0_q;
    ob1_d = ob1_q;
    if (pop) begin
      ob0_d = ob1_q;
    end
    if (inflight_q) begin
      if (ob_after_pop == 2'd0) begin
        ob0_d = ram_dout;
      end else begin
        ob1_d = ram_dout;
      end
    end

    fifo_count_d = {1'b0, ram_cnt_d} + {9'd0, rd_issue} + {8'd0, ob_cnt_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= 8'd0;
      rd_ptr_q     <= 8'd0;
      ram_cnt_q    <= 9'd0;
      inflight_q   <= 1'b0;
      ob_cnt_q     <= 2'd0;
      ob0_q        <= 64'd0;
      ob1_q        <= 64'd0;
      fifo_count_q <= 10'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ram_cnt_q    <= ram_cnt_d;
      inflight_q   <= rd_issue;
      ob_cnt_q     <= ob_cnt_d;
      ob0_q        <= ob0_d;
      ob1_q        <= ob1_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  generate
    if (ASSERT_ON != 0) begin : g_assert
      a_no_same_addr_rw: assert property (@(posedge clk) !(ram_we && ram_re && (ram_wa == ram_ra)));
      a_no_ram_in_rst:   assert property (@(posedge clk) rst |-> !(ram_we || ram_re));
    end
  endgenerate

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_256x64.sv
// Bench for nv_ram_fifo_ctrl_256x64: vector table, fill/stream/reset sequences, random traffic vs a queue model.
module tb_nv_ram_fifo_ctrl_256x64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_pvld = 1'b0;
  logic        wr_prdy;
  logic [63:0] wr_pd = 64'd0;
  logic        rd_pvld;
  logic        rd_prdy = 1'b0;
  logic [63:0] rd_pd;
  logic        ram_we;
  logic [7:0]  ram_wa;
  logic [63:0] ram_di;
  logic        ram_re;
  logic [7:0]  ram_ra;
  logic [63:0] ram_dout = 64'd0;
  logic [31:0] pwrbus_ram_pd_in = 32'd0;
  logic [31:0] pwrbus_ram_pd;
  logic [9:0]  fifo_count;
  logic        idle;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] mem [256];
  logic [63:0] model_q [$];

  always #5 clk = ~clk;

  nv_ram_fifo_ctrl_256x64 #(.ASSERT_ON(1)) dut (
    .clk(clk), .rst(rst),
    .wr_pvld(wr_pvld), .wr_prdy(wr_prdy), .wr_pd(wr_pd),
    .rd_pvld(rd_pvld), .rd_prdy(rd_prdy), .rd_pd(rd_pd),
    .ram_we(ram_we), .ram_wa(ram_wa), .ram_di(ram_di),
    .ram_re(ram_re), .ram_ra(ram_ra), .ram_dout(ram_dout),
    .pwrbus_ram_pd_in(pwrbus_ram_pd_in), .pwrbus_ram_pd(pwrbus_ram_pd),
    .fifo_count(fifo_count), .idle(idle)
  );

  // Behavioural two-port RAM: registered read data one cycle after ram_re.
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ram_dout <= mem[ram_ra];
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: the FIFO is an ordered queue of accepted words; occupancy is its size.
  always @(negedge clk) begin
    if (rst) begin
      model_q.delete();
      chk("rst_no_we", ram_we, 1'b0);
      chk("rst_no_re", ram_re, 1'b0);
      chk("rst_wr_prdy", wr_prdy, 1'b0);
    end else begin
      chk("mon_count", fifo_count, model_q.size());
      chk("mon_idle", idle, model_q.size() == 0);
      chk("mon_we_is_push", ram_we, wr_pvld && wr_prdy);
      if (model_q.size() < 256) chk("mon_wr_prdy_room", wr_prdy, 1'b1);
      if (model_q.size() == 258) chk("mon_wr_prdy_full", wr_prdy, 1'b0);
      if (model_q.size() == 0) chk("mon_rd_pvld_empty", rd_pvld, 1'b0);
      if (ram_we && ram_re) chk("mon_same_addr", ram_wa == ram_ra, 1'b0);
      if (rd_pvld && rd_prdy) begin
        if (model_q.size() == 0) chk("mon_pop_underflow", 1'b1, 1'b0);
        else chk("mon_data", rd_pd, model_q.pop_front());
      end
      if (wr_pvld && wr_prdy) model_q.push_back(wr_pd);
    end
  end

  typedef struct {
    logic        wv;
    logic        rr;
    logic [63:0] wd;
    logic        e_wrdy;
    logic        e_rvld;
    logic [63:0] e_rpd;
    logic [9:0]  e_cnt;
    logic        e_we;
    logic        e_re;
    logic [7:0]  e_ra;
  } vec_t;

  vec_t vt [12];

  task automatic cyc_drive(input logic wv, input logic [63:0] wd, input logic rr);
    @(posedge clk);
    #1;
    wr_pvld = wv;
    wr_pd   = wd;
    rd_prdy = rr;
  endtask

  task automatic fill_full(input logic [63:0] base);
    int acc;
    acc = 0;
    for (int c = 0; c < 300; c++) begin
      cyc_drive(1'b1, base + 64'(acc), 1'b0);
      @(negedge clk);
      if (wr_prdy) acc++;
    end
    chk("fill_accepted", 64'(acc), 64'd258);
    cyc_drive(1'b0, 64'd0, 1'b0);
    @(negedge clk);
    chk("fill_count", fifo_count, 10'd258);
    chk("fill_wr_prdy", wr_prdy, 1'b0);
    chk("fill_rd_pvld", rd_pvld, 1'b1);
    chk("fill_rd_pd", rd_pd, base);
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (fifo_count != 10'd0 && c < 400) begin
      cyc_drive(1'b0, 64'd0, 1'b1);
      @(negedge clk);
      c++;
    end
    chk("drain_done", fifo_count, 10'd0);
  endtask

  initial begin
    logic [63:0] w0, w1, w2, nw;
    int pops, bubbles, stalls, got;
    bit started;

    w0 = 64'hA5A5_0000_0000_0001;
    w1 = 64'h1111_2222_3333_4444;
    w2 = 64'h5555_6666_7777_8888;
    //          wv    rr    wd     wrdy  rvld  rpd    cnt    we    re    ra
    vt[0]  = '{1'b1, 1'b1, w0,    1'b1, 1'b0, 64'd0, 10'd0, 1'b1, 1'b0, 8'd0};
    vt[1]  = '{1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 64'd0, 10'd1, 1'b0, 1'b1, 8'd0};
    vt[2]  = '{1'b0, 1'b1, 64'd0, 1'b1, 1'b0, 64'd0, 10'd1, 1'b0, 1'b0, 8'd0};
    vt[3]  = '{1'b0, 1'b1, 64'd0, 1'b1, 1'b1, w0,    10'd1, 1'b0, 1'b0, 8'd0};
    vt[4]  = '{1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 10'd0, 1'b0, 1'b0, 8'd0};
    vt[5]  = '{1'b1, 1'b0, w1,    1'b1, 1'b0, 64'd0, 10'd0, 1'b1, 1'b0, 8'd0};
    vt[6]  = '{1'b1, 1'b0, w2,    1'b1, 1'b0, 64'd0, 10'd1, 1'b1, 1'b1, 8'd1};
    vt[7]  = '{1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 10'd2, 1'b0, 1'b1, 8'd2};
    vt[8]  = '{1'b0, 1'b0, 64'd0, 1'b1, 1'b1, w1,    10'd2, 1'b0, 1'b0, 8'd0};
    vt[9]  = '{1'b0, 1'b1, 64'd0, 1'b1, 1'b1, w1,    10'd2, 1'b0, 1'b0, 8'd0};
    vt[10] = '{1'b0, 1'b1, 64'd0, 1'b1, 1'b1, w2,    10'd1, 1'b0, 1'b0, 8'd0};
    vt[11] = '{1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 10'd0, 1'b0, 1'b0, 8'd0};

    // Reset with a pending push and the power bus driven.
    wr_pvld = 1'b1;
    wr_pd   = 64'hDEAD_BEEF_0000_0000;
    pwrbus_ram_pd_in = 32'h1234_5678;
    #1;
    chk("pwr_in_reset", pwrbus_ram_pd, 32'h1234_5678);
    repeat (3) @(negedge clk);
    chk("rst_fifo_count", fifo_count, 10'd0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_rd_pvld", rd_pvld, 1'b0);
    chk("rst_rd_pd", rd_pd, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_pvld = 1'b0;
    @(negedge clk);
    chk("rel_wr_prdy", wr_prdy, 1'b1);
    chk("rel_idle", idle, 1'b1);
    chk("rel_count", fifo_count, 10'd0);
    chk("rel_rd_pvld", rd_pvld, 1'b0);
    chk("rel_rd_pd", rd_pd, 64'd0);
    chk("rel_re", ram_re, 1'b0);
    chk("pwr_no_reset", pwrbus_ram_pd, 32'h1234_5678);
    pwrbus_ram_pd_in = 32'hA5A5_5A5A;
    #1;
    chk("pwr_change", pwrbus_ram_pd, 32'hA5A5_5A5A);

    for (int i = 0; i < 12; i++) begin
      cyc_drive(vt[i].wv, vt[i].wd, vt[i].rr);
      @(negedge clk);
      chk($sformatf("vec%0d_wr_prdy", i), wr_prdy, vt[i].e_wrdy);
      chk($sformatf("vec%0d_rd_pvld", i), rd_pvld, vt[i].e_rvld);
      chk($sformatf("vec%0d_count", i), fifo_count, vt[i].e_cnt);
      chk($sformatf("vec%0d_ram_we", i), ram_we, vt[i].e_we);
      chk($sformatf("vec%0d_ram_re", i), ram_re, vt[i].e_re);
      if (vt[i].e_rvld) chk($sformatf("vec%0d_rd_pd", i), rd_pd, vt[i].e_rpd);
      if (vt[i].e_re) chk($sformatf("vec%0d_ram_ra", i), ram_ra, vt[i].e_ra);
    end

    // Fill to 258, single pop re-opens the write side on the next cycle, then drain in order.
    fill_full(64'hF000_0000_0000_0000);
    cyc_drive(1'b0, 64'd0, 1'b1);
    @(negedge clk);
    chk("pop_full_ram_re", ram_re, 1'b1);
    cyc_drive(1'b0, 64'd0, 1'b0);
    @(negedge clk);
    chk("pop_full_wr_prdy", wr_prdy, 1'b1);
    chk("pop_full_count", fifo_count, 10'd257);
    drain();

    // Streaming across the pointer wrap with both sides always ready.
    pops = 0; bubbles = 0; stalls = 0; started = 1'b0;
    for (int c = 0; c < 1020; c++) begin
      cyc_drive(c < 1000, 64'h5000_0000_0000_0000 + 64'(c), 1'b1);
      @(negedge clk);
      if (wr_pvld && !wr_prdy) stalls++;
      if (rd_pvld) begin
        started = 1'b1;
        pops++;
      end else if (started && pops < 1000) begin
        bubbles++;
      end
    end
    chk("stream_pops", 64'(pops), 64'd1000);
    chk("stream_bubbles", 64'(bubbles), 64'd0);
    chk("stream_stalls", 64'(stalls), 64'd0);

    // Random backpressure on both sides.
    for (int c = 0; c < 10000; c++) begin
      cyc_drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    drain();

    // Reset while nearly full with a RAM read in flight; only post-reset data may come out.
    fill_full(64'hE000_0000_0000_0000);
    cyc_drive(1'b0, 64'd0, 1'b1);
    @(negedge clk);
    chk("prerst_ram_re", ram_re, 1'b1);
    @(posedge clk);
    #1;
    rd_prdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_count", fifo_count, 10'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_count", fifo_count, 10'd0);
    chk("postrst_rd_pvld", rd_pvld, 1'b0);
    chk("postrst_idle", idle, 1'b1);
    nw = 64'h0123_4567_89AB_CDEF;
    cyc_drive(1'b1, nw, 1'b1);
    cyc_drive(1'b0, 64'd0, 1'b1);
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(negedge clk);
      if (rd_pvld) begin
        got = 1;
        chk("postrst_new_data", rd_pd, nw);
      end
    end
    chk("postrst_seen", 64'(got), 64'd1);
    repeat (2) @(negedge clk);
    chk("postrst_empty", fifo_count, 10'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
